// File: rtl/fp_addsub_arbiter_if.sv
// Bundle of the two requester ports, their response ports and the shared add/sub datapath port.
// master drives requests, response readies, flush0 and dp_result; slave is the arbiter.
interface fp_addsub_arbiter_if #(
  parameter int unsigned TAG_W = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic             req0_sub;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic             req1_sub;
  logic [TAG_W-1:0] req1_tag;

  logic             resp0_valid;
  logic             resp0_ready;
  logic [31:0]      resp0_result;
  logic [TAG_W-1:0] resp0_tag;

  logic             resp1_valid;
  logic             resp1_ready;
  logic [31:0]      resp1_result;
  logic [TAG_W-1:0] resp1_tag;

  logic             flush0;
  logic             dp_en;
  logic [31:0]      dp_num1;
  logic [31:0]      dp_num2;
  logic             dp_add_sub;
  logic [31:0]      dp_result;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub, req0_tag,
    output req1_valid, req1_a, req1_b, req1_sub, req1_tag,
    output resp0_ready, resp1_ready, flush0, dp_result,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_result, resp0_tag,
    input  resp1_valid, resp1_result, resp1_tag,
    input  dp_en, dp_num1, dp_num2, dp_add_sub, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_sub, req1_tag,
    input  resp0_ready, resp1_ready, flush0, dp_result,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_result, resp0_tag,
    output resp1_valid, resp1_result, resp1_tag,
    output dp_en, dp_num1, dp_num2, dp_add_sub, busy
  );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// Two-requester arbiter for a shared LAT-stage FP add/sub pipeline with owner/tag tracking.
// Define FP_ADDSUB_RR_EN for round-robin arbitration; default is fixed priority to req0.
module fp_addsub_arbiter #(
  parameter int unsigned LAT   = 3,
  parameter int unsigned TAG_W = 5
) (
  input logic                clk,
  input logic                reset,
  fp_addsub_arbiter_if.slave bus
);

  // Tracking pipe: slot LAT-1 is the head, aligned with dp_result.
  logic [LAT-1:0]            vld_q, vld_d;
  logic [LAT-1:0]            own_q, own_d;
  logic [LAT-1:0][TAG_W-1:0] tag_q, tag_d;

  logic [LAT:0]              vld_sh, own_sh;
  logic [LAT:0][TAG_W-1:0]   tag_sh;
  logic [LAT-1:0]            vld_mv, own_mv;
  logic [LAT-1:0][TAG_W-1:0] tag_mv;

  logic head_vld, head_own, head_ready;
  logic elig0, elig1, gnt0, gnt1, acc0, acc1, dp_en;

  assign head_vld   = vld_q[LAT-1];
  assign head_own   = own_q[LAT-1];
  assign head_ready = head_own ? bus.resp1_ready : bus.resp0_ready;

  // A req0 head being flushed must not hold the pipe.
  assign dp_en = !(head_vld && !head_ready) || (bus.flush0 && !head_own);

  assign elig0 = bus.req0_valid && !bus.flush0;
  assign elig1 = bus.req1_valid;

`ifdef FP_ADDSUB_RR_EN
  logic rr_q, rr_d;

  // rr_q == 0 favours req0 when both are eligible.
  always_comb begin
    gnt0 = elig0 && (!elig1 || !rr_q);
    gnt1 = elig1 && (!elig0 || rr_q);
    rr_d = rr_q;
    if (acc0) begin
      rr_d = 1'b1;
    end else if (acc1) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  always_comb begin
    gnt0 = elig0;
    gnt1 = elig1 && !elig0;
  end
`endif

  assign acc0 = gnt0 && dp_en && !reset;
  assign acc1 = gnt1 && dp_en && !reset;

  always_comb begin
    vld_sh = {vld_q, acc0 | acc1};
    own_sh = {own_q, acc1};
    tag_sh = {tag_q, (acc1 ? bus.req1_tag : bus.req0_tag)};
    if (dp_en) begin
      vld_mv = vld_sh[LAT-1:0];
      own_mv = own_sh[LAT-1:0];
      tag_mv = tag_sh[LAT-1:0];
    end else begin
      vld_mv = vld_q;
      own_mv = own_q;
      tag_mv = tag_q;
    end
    // flush0 kills every req0-owned slot, wherever it ends up this edge.
    vld_d = vld_mv & (bus.flush0 ? own_mv : {LAT{1'b1}});
    own_d = own_mv;
    tag_d = tag_mv;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      own_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
      tag_q <= tag_d;
    end
  end

  assign bus.req0_ready   = acc0;
  assign bus.req1_ready   = acc1;
  assign bus.dp_en        = dp_en;
  assign bus.dp_num1      = gnt1 ? bus.req1_a   : bus.req0_a;
  assign bus.dp_num2      = gnt1 ? bus.req1_b   : bus.req0_b;
  assign bus.dp_add_sub   = gnt1 ? bus.req1_sub : bus.req0_sub;

  assign bus.resp0_valid  = head_vld && !head_own && !bus.flush0;
  assign bus.resp1_valid  = head_vld && head_own;
  assign bus.resp0_result = bus.dp_result;
  assign bus.resp1_result = bus.dp_result;
  assign bus.resp0_tag    = tag_q[LAT-1];
  assign bus.resp1_tag    = tag_q[LAT-1];
  assign bus.busy         = |vld_q;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Scoreboard bench for fp_addsub_arbiter with a table-driven LAT-stage datapath stub.
module tb_fp_addsub_arbiter;
  localparam int unsigned LAT   = 3;
  localparam int unsigned TAG_W = 5;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             sub;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } op_t;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fp_addsub_arbiter_if #(.TAG_W(TAG_W)) r ();
  fp_addsub_arbiter #(.LAT(LAT), .TAG_W(TAG_W)) dut (.clk(clk), .reset(reset), .bus(r));

  op_t  pend0[$], pend1[$], sb0[$], sb1[$];
  bit   glog[$];
  op_t  mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] dp_pipe [LAT];

  function automatic op_t mk_op(logic [31:0] a, logic [31:0] b, logic sub,
                                logic [TAG_W-1:0] tag, logic [31:0] exp);
    op_t o;
    o.a = a; o.b = b; o.sub = sub; o.tag = tag; o.exp = exp;
    return o;
  endfunction

  // Hand-computed single-precision results for the operand pairs used below.
  function automatic logic [31:0] fp_ref(logic [31:0] a, logic [31:0] b, logic sub);
    case ({a, b, sub})
      {32'h3F800000, 32'h40000000, 1'b0}: return 32'h40400000;
      {32'h40400000, 32'h3F800000, 1'b1}: return 32'h40000000;
      {32'h40A00000, 32'h3F800000, 1'b1}: return 32'h40800000;
      {32'h3F800000, 32'h3F800000, 1'b0}: return 32'h40000000;
      {32'h3F000000, 32'h3F000000, 1'b0}: return 32'h3F800000;
      {32'h3F800000, 32'h40000000, 1'b1}: return 32'hBF800000;
      {32'h40400000, 32'h40400000, 1'b0}: return 32'h40C00000;
      {32'h40000000, 32'h40000000, 1'b0}: return 32'h40800000;
      {32'h40800000, 32'h40000000, 1'b1}: return 32'h40000000;
      default:                            return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (r.dp_en) begin
      dp_pipe[0] <= fp_ref(r.dp_num1, r.dp_num2, r.dp_add_sub);
      for (int i = 1; i < int'(LAT); i++) dp_pipe[i] <= dp_pipe[i-1];
    end
  end
  assign r.dp_result = dp_pipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Driver: present queued ops, log accepts and push expectations.
  initial begin
    r.req0_valid = 0; r.req0_a = 0; r.req0_b = 0; r.req0_sub = 0; r.req0_tag = 0;
    r.req1_valid = 0; r.req1_a = 0; r.req1_b = 0; r.req1_sub = 0; r.req1_tag = 0;
    forever begin
      @(posedge clk); #1;
      r.req0_valid = (pend0.size() != 0);
      if (pend0.size() != 0) begin
        r.req0_a = pend0[0].a; r.req0_b = pend0[0].b;
        r.req0_sub = pend0[0].sub; r.req0_tag = pend0[0].tag;
      end
      r.req1_valid = (pend1.size() != 0);
      if (pend1.size() != 0) begin
        r.req1_a = pend1[0].a; r.req1_b = pend1[0].b;
        r.req1_sub = pend1[0].sub; r.req1_tag = pend1[0].tag;
      end
      @(negedge clk);
      if (!reset && r.req0_valid && r.req0_ready) begin
        sb0.push_back(pend0.pop_front());
        glog.push_back(1'b0);
      end
      if (!reset && r.req1_valid && r.req1_ready) begin
        sb1.push_back(pend1.pop_front());
        glog.push_back(1'b1);
      end
    end
  end

  // Monitor: every completed response handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (r.resp0_valid && r.resp0_ready) begin
        if (sb0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL resp0_unexpected: got result %h tag %0d, required no response",
                   r.resp0_result, r.resp0_tag);
        end else begin
          mon_e = sb0.pop_front();
          check("resp0_result", 64'(r.resp0_result), 64'(mon_e.exp));
          check("resp0_tag", 64'(r.resp0_tag), 64'(mon_e.tag));
        end
      end
      if (r.resp1_valid && r.resp1_ready) begin
        if (sb1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL resp1_unexpected: got result %h tag %0d, required no response",
                   r.resp1_result, r.resp1_tag);
        end else begin
          mon_e = sb1.pop_front();
          check("resp1_result", 64'(r.resp1_result), 64'(mon_e.exp));
          check("resp1_tag", 64'(r.resp1_tag), 64'(mon_e.tag));
        end
      end
    end
  end

  task automatic wait_pend(input int q, input int budget);
    int n = 0;
    while (((q == 0) ? pend0.size() : pend1.size()) != 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check("wait_pend_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 || sb0.size() != 0 || sb1.size() != 0
            || r.busy) && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check("wait_idle_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    sb0.delete(); sb1.delete(); glog.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(r.busy), 64'd0);
    check("rst_resp0_valid", 64'(r.resp0_valid), 64'd0);
    check("rst_resp1_valid", 64'(r.resp1_valid), 64'd0);
    check("rst_dp_en", 64'(r.dp_en), 64'd1);
    check("rst_req_ready", 64'({r.req0_ready, r.req1_ready}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // exp[i] is the owner of the i-th accepted grant.
  task automatic check_glog(input string name, input logic [3:0] exp);
    check({name, "_count"}, 64'(glog.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < glog.size()) check(name, 64'(glog[i]), 64'(exp[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    r.flush0 = 1'b0; r.resp0_ready = 1'b1; r.resp1_ready = 1'b1;
    do_reset();

    // Single add: latency and idle afterwards.
    pend0.push_back(mk_op(32'h3F800000, 32'h40000000, 1'b0, 5'd5, 32'h40400000));
    wait_pend(0, 20);
    for (int k = 0; k < int'(LAT); k++) begin
      @(negedge clk);
      check("t1_latency", 64'(r.resp0_valid), 64'(k == int'(LAT) - 1));
    end
    wait_idle(50);
    check("t1_busy_idle", 64'(r.busy), 64'd0);

    // Dual back-to-back requests.
    do_reset();
    pend0.push_back(mk_op(32'h40400000, 32'h3F800000, 1'b1, 5'd1, 32'h40000000));
    pend0.push_back(mk_op(32'h40A00000, 32'h3F800000, 1'b1, 5'd2, 32'h40800000));
    pend1.push_back(mk_op(32'h3F800000, 32'h3F800000, 1'b0, 5'd9, 32'h40000000));
    pend1.push_back(mk_op(32'h3F000000, 32'h3F000000, 1'b0, 5'd10, 32'h3F800000));
    wait_idle(100);
`ifdef FP_ADDSUB_RR_EN
    check_glog("t2_grant", 4'b1010);
`else
    check_glog("t2_grant", 4'b1100);
`endif

    // Owner stall on req1 head.
    @(posedge clk); #1;
    r.resp1_ready = 1'b0;
    pend1.push_back(mk_op(32'h3F800000, 32'h40000000, 1'b1, 5'd17, 32'hBF800000));
    wait_pend(1, 20);
    repeat (LAT) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("t3_dp_en", 64'(r.dp_en), 64'd0);
      check("t3_head_valid", 64'(r.resp1_valid), 64'd1);
      check("t3_head_result", 64'(r.resp1_result), 64'hBF800000);
      check("t3_head_tag", 64'(r.resp1_tag), 64'd17);
      if (k == 0) pend0.push_back(mk_op(32'h40400000, 32'h40400000, 1'b0, 5'd3, 32'h40C00000));
      else check("t3_no_issue", 64'(r.req0_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    r.resp1_ready = 1'b1;
    wait_idle(100);

    // Both requesting, three req0 ops against one req1 op.
    do_reset();
    pend0.push_back(mk_op(32'h3F800000, 32'h3F800000, 1'b0, 5'd4, 32'h40000000));
    pend0.push_back(mk_op(32'h40000000, 32'h40000000, 1'b0, 5'd5, 32'h40800000));
    pend0.push_back(mk_op(32'h40800000, 32'h40000000, 1'b1, 5'd6, 32'h40000000));
    pend1.push_back(mk_op(32'h40400000, 32'h3F800000, 1'b1, 5'd20, 32'h40000000));
    wait_idle(100);
`ifdef FP_ADDSUB_RR_EN
    check_glog("t4_grant", 4'b0010);
`else
    check_glog("t4_grant", 4'b1000);
`endif

    // Flush: three req0 ops stalled in the pipe, one req1 op waiting.
    @(posedge clk); #1;
    r.resp0_ready = 1'b0;
    pend0.push_back(mk_op(32'h3F800000, 32'h3F800000, 1'b0, 5'd11, 32'h40000000));
    pend0.push_back(mk_op(32'h40000000, 32'h40000000, 1'b0, 5'd12, 32'h40800000));
    pend0.push_back(mk_op(32'h40400000, 32'h40400000, 1'b0, 5'd13, 32'h40C00000));
    wait_pend(0, 20);
    pend1.push_back(mk_op(32'h40A00000, 32'h3F800000, 1'b1, 5'd27, 32'h40800000));
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_pre_dp_en", 64'(r.dp_en), 64'd0);
    check("t5_pre_req1_ready", 64'(r.req1_ready), 64'd0);
    check("t5_pre_resp0_valid", 64'(r.resp0_valid), 64'd1);
    @(posedge clk); #1;
    r.flush0 = 1'b1;
    sb0.delete();
    @(negedge clk);
    check("t5_req0_ready", 64'(r.req0_ready), 64'd0);
    check("t5_resp0_valid", 64'(r.resp0_valid), 64'd0);
    check("t5_dp_en", 64'(r.dp_en), 64'd1);
    check("t5_req1_ready", 64'(r.req1_ready), 64'd1);
    @(posedge clk); #1;
    r.flush0 = 1'b0;
    r.resp0_ready = 1'b1;
    wait_idle(100);

    // Reset with a full pipe discards everything.
    @(posedge clk); #1;
    r.resp0_ready = 1'b0;
    pend0.push_back(mk_op(32'h3F800000, 32'h40000000, 1'b0, 5'd21, 32'h40400000));
    pend0.push_back(mk_op(32'h40400000, 32'h3F800000, 1'b1, 5'd22, 32'h40000000));
    pend0.push_back(mk_op(32'h3F000000, 32'h3F000000, 1'b0, 5'd23, 32'h3F800000));
    wait_pend(0, 20);
    @(negedge clk);
    check("t6_busy_before", 64'(r.busy), 64'd1);
    do_reset();
    r.resp0_ready = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check("t6_busy_after", 64'(r.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_addsub_arbiter.md
# fp_addsub_arbiter

Shares one pipelined single-precision add/sub datapath between two requesters: req0 is the core FP execute stage, req1 is the FMADD accumulate path. It arbitrates issue, tracks the owner and tag of every in-flight operation, and routes each result back to its owner. When the owner of the completing result is not ready, it stalls the shared pipeline. The block sits between the FPU issue logic and the fadd/fsub datapath, whose operand extraction/alignment and normalisation stages it feeds.

## Interface
- LAT, 3: datapath latency in pipeline stages (≥1); equals the number of `dp_en`-gated register stages in the datapath.
- TAG_W, 5: width of the requester tag (e.g. destination register index).
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request N (N = 0, 1) has an operation.
- reqN_ready  out  1  request N accepted this cycle.
- reqN_a, reqN_b  in  32  IEEE-754 operands.
- reqN_sub  in  1  1 = a−b, 0 = a+b.
- reqN_tag  in  TAG_W  opaque tag, returned with the result.
- respN_valid  out  1  result for requester N is available.
- respN_ready  in  1  requester N consumes the result.
- respN_result  out  32  result.
- respN_tag  out  TAG_W  tag of the result.
- flush0  in  1  kill all pending and in-flight req0 work (branch mispredict or trap).
- dp_en  out  1  datapath stage enable; the pipeline advances only when this is 1.
- dp_num1, dp_num2  out  32  operands to the datapath input stage.
- dp_add_sub  out  1  op to the datapath.
- dp_result  in  32  datapath output-stage result.
- busy  out  1  any in-flight slot is valid.

## Operation
- Tracking pipe: LAT slots of {valid, owner, tag}. Slot 0 loads on accept. Slot i moves to slot i+1 when `dp_en`=1. Slot LAT−1 aligns with `dp_result`.
- Head = slot LAT−1. `respN_valid` = head.valid & head.owner==N & !(N==0 & flush0).
- `respN_result` = `dp_result`; `respN_tag` = head.tag (both driven to both requesters).
- `dp_en` = !(head.valid & !resp_ready[head.owner]) | (flush0 & head.owner==0).
- Grant:
  - Only one requester valid: that requester wins.
  - Both valid: the arbitration policy decides (see Configuration).
  - `req0` is ineligible while flush0=1.
- `reqN_ready` = grant_N & dp_en. An accept loads slot 0 with {1, N, reqN_tag}. No accept (or `dp_en`=1 with no grant) loads slot 0 invalid.
- `dp_num1`/`dp_num2`/`dp_add_sub` are muxed from the granted requester. They are held at req0's values when there is no grant.
- flush0: every slot with owner 0 has its valid bit cleared at the edge. Slot movement still follows `dp_en`. The flushed head does not stall.
- Reset values:
  - All slots invalid.
  - RR pointer favours req0.
  - resp*_valid=0, req*_ready=0, busy=0, dp_en=1.

## Timing
- Throughput: 1 issue/cycle when neither owner stalls.
- Latency: an op accepted on edge E presents `respN_valid` in the cycle after edge E+LAT−1. For LAT=1, the response is visible in the cycle right after acceptance.
- Stall: the head holds, with stable result and tag, until its owner's ready is 1. No issue occurs during a stall. A non-owner's ready has no effect.
- Simultaneous head completion and new accept in the same cycle is allowed.
- Reset asserted mid-operation discards all in-flight ops. No response is produced for them.
- Requester rules:
  - Requesters must hold valid/operands/tag stable until ready.
  - Responders must not drop valid without a handshake, except req0 under flush0.

## Configuration
- `FP_ADDSUB_RR_EN` defined:
  - Round-robin arbitration. A 1-bit pointer flips to the other requester after each accepted grant.
  - Under sustained dual requests, grants alternate 0,1,0,1…
- Not defined:
  - Fixed priority, req0 always wins. The pointer is not implemented.
  - req1 is granted only in cycles where req0_valid=0 or flush0=1.

## Test plan
- Single add, LAT=3: req0 a=0x3F800000, b=0x40000000, sub=0, tag=5, resp0_ready=1 → resp0_valid after 2 edges past accept, result 0x40400000, tag 5; busy returns to 0.
- Dual back-to-back, RR enabled: req0 (0x40400000 − 0x3F800000) and req1 (0x3F800000 + 0x3F800000) held valid for 4 cycles → grants alternate starting with req0; results 0x40000000 to resp0 and 0x40000000 to resp1, in issue order.
- Owner stall: resp1_ready=0 while the head belongs to req1 → dp_en=0, no issue, head stable for 5 cycles; release → result delivered once, pipe resumes.
- Flush: three req0 ops in flight plus one req1 op, pulse flush0 → no resp0_valid for the killed ops, the req1 result still delivered with the correct tag, req0_ready=0 in the flush cycle.
- Fixed priority (macro undefined): both valid for 3 cycles → req0 granted 3 times, req1 granted on the first cycle req0_valid drops.
- Reset mid-flight: assert reset with 3 slots valid → next cycle busy=0, resp*_valid=0, dp_en=1.
